// File: rtl/floor_call_register.sv
// rtl/floor_call_register.sv - debounced hall-call register with up/down call bitmaps
// Optional macro CALL_ERR_EN adds a call_err pulse for each rejected call.
module floor_call_register #(
   parameter int FLOORS          = 4,
   parameter int FLOOR_W         = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               btn,
   input  logic               switch_u_d,
   input  logic [FLOOR_W-1:0] floor_sel,
   input  logic               clear_valid,
   input  logic [FLOOR_W-1:0] clear_floor,
   output logic [FLOORS-1:0]  up_calls,
   output logic [FLOORS-1:0]  down_calls,
   output logic               call_valid,
   output logic [1:0]         up_or_down,
   output logic [FLOOR_W-1:0] actualStage,
`ifdef CALL_ERR_EN
   output logic               call_err,
`endif
   output logic               pending
);

   localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [FLOOR_W:0] FLOOR_LIM = (FLOOR_W+1)'(FLOORS);
   localparam logic [FLOOR_W:0] FLOOR_TOP = (FLOOR_W+1)'(FLOORS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      HELD    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             rel_ok, rel_ok_nx;
   logic             sync_1, btn_s;
   logic             accept;

   logic [FLOOR_W:0] floor_ext;
   logic             legal;
   logic [FLOORS-1:0] clr_mask, set_hit, up_nx, down_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= 1'b0;
         btn_s  <= 1'b0;
      end else begin
         sync_1 <= btn;
         btn_s  <= sync_1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         rel_ok <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         rel_ok <= rel_ok_nx;
      end
   end

   // rel_ok stays low after reset until the button has been seen released
   // long enough, so a press held through reset never produces a call.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      rel_ok_nx = rel_ok;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (!rel_ok) begin
               if (btn_s) begin
                  cnt_nx = '0;
               end else if (cnt == CNT_LAST) begin
                  rel_ok_nx = 1'b1;
                  cnt_nx    = '0;
               end else begin
                  cnt_nx = cnt + CNT_ONE;
               end
            end else if (btn_s) begin
               state_nx = ARM;
               cnt_nx   = '0;
            end
         end
         ARM: begin
            if (!btn_s) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = HELD;
               cnt_nx   = '0;
               accept   = 1'b1;
            end else begin
               cnt_nx = cnt + CNT_ONE;
            end
         end
         HELD: begin
            if (!btn_s) begin
               state_nx = RELEASE;
               cnt_nx   = '0;
            end
         end
         RELEASE: begin
            if (btn_s) begin
               state_nx = HELD;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_comb begin
      floor_ext = {1'b0, floor_sel};
      legal     = (floor_ext < FLOOR_LIM)
               && !(switch_u_d && (floor_ext == FLOOR_TOP))
               && !(!switch_u_d && (floor_sel == '0));
   end

   // Clear is applied before set so a fresh call to the served floor survives.
   always_comb begin
      clr_mask = '0;
      set_hit  = '0;
      for (int i = 0; i < FLOORS; i++) begin
         clr_mask[i] = clear_valid && (clear_floor == FLOOR_W'(i));
         set_hit[i]  = accept && legal && (floor_sel == FLOOR_W'(i));
      end
      up_nx   = (up_calls & ~clr_mask)   | (switch_u_d  ? set_hit : '0);
      down_nx = (down_calls & ~clr_mask) | (!switch_u_d ? set_hit : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up_calls    <= '0;
         down_calls  <= '0;
         call_valid  <= 1'b0;
         up_or_down  <= 2'b00;
         actualStage <= '0;
      end else begin
         up_calls   <= up_nx;
         down_calls <= down_nx;
         call_valid <= accept && legal;
         if (accept && legal) begin
            up_or_down  <= switch_u_d ? 2'b11 : 2'b01;
            actualStage <= floor_sel;
         end
      end
   end

`ifdef CALL_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         call_err <= 1'b0;
      end else begin
         call_err <= accept && !legal;
      end
   end
`endif

   assign pending = (|up_calls) | (|down_calls);

endmodule
